// File: rtl/conv_filter_stream.sv
// conv_filter_stream: streaming N x N per-channel convolution with zero padding, clamp and bypass
//   clk, rst                    : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready           : input handshake; in_data has channel 0 in the MSBs
//   in_sop/in_eop               : frame start/end flags travelling with in_data
//   out_valid/out_ready         : output handshake; out_data, out_sop/out_eop aligned with their pixel
//   coef_we/coef_addr/coef_data : kernel write; entry i*N+j weights the pixel i lines up, j pixels left
//   bypass                      : pass the accepted pixel through unfiltered
module conv_filter_stream #(
    parameter int N          = 3,
    parameter int LINE_WIDTH = 640,
    parameter int CHANNELS   = 3,
    parameter int CH_WIDTH   = 8,
    parameter int COEF_WIDTH = 8,
    parameter int SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*CH_WIDTH-1:0] in_data,
    input  logic                         in_sop,
    input  logic                         in_eop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*CH_WIDTH-1:0] out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    input  logic                         coef_we,
    input  logic [$clog2(N*N)-1:0]       coef_addr,
    input  logic [COEF_WIDTH-1:0]        coef_data,
    input  logic                         bypass
);
    localparam int TAPS = N * N;
    localparam int DW   = CHANNELS * CH_WIDTH;
    localparam int PW   = CH_WIDTH + COEF_WIDTH + 1;
    localparam int SW   = PW + $clog2(TAPS);
    localparam int XW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int RW   = $clog2(N);
    localparam int MAXV = 2 ** CH_WIDTH - 1;

    logic signed [COEF_WIDTH-1:0] coef [TAPS];
    logic [DW-1:0] lb [N-1][LINE_WIDTH];
    logic [DW-1:0] hist [N][N-1];
    logic [XW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [DW-1:0] colv [N];
    logic [DW-1:0] tap [N][N];
    logic adv, accept;
    logic signed [PW-1:0] prod_d [CHANNELS][TAPS];
    logic signed [PW-1:0] prod_q [CHANNELS][TAPS];
    logic signed [SW-1:0] sum_d [CHANNELS];
    logic signed [SW-1:0] sum_q [CHANNELS];
    logic signed [SW-1:0] sh [CHANNELS];
    logic [DW-1:0] res;
    logic v1, v2, byp1, byp2, sop1, sop2, eop1, eop2;
    logic [DW-1:0] pix1, pix2;

    // the whole pipe advances together; it only stalls when the output register is blocked
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // an sop pixel is column 0 / row 0 regardless of where the counters were
    always_comb begin
        cur_col = in_sop ? '0 : col;
        cur_row = in_sop ? '0 : row;
        colv[0] = in_data;
        for (int i = 1; i < N; i++) colv[i] = lb[i-1][cur_col];
        for (int i = 0; i < N; i++) begin
            tap[i][0] = (int'(cur_row) < i) ? '0 : colv[i];
            for (int j = 1; j < N; j++)
                tap[i][j] = (int'(cur_row) < i || int'(cur_col) < j) ? '0 : hist[i][j-1];
        end
    end

    // products use the kernel as it stands before any write in the same cycle
    always_comb begin
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++)
                prod_d[c][k] = PW'($signed({1'b0, tap[k/N][k%N][DW-1-c*CH_WIDTH -: CH_WIDTH]})) * PW'(coef[k]);
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum_d[c] = '0;
            for (int k = 0; k < TAPS; k++) sum_d[c] = sum_d[c] + SW'(prod_q[c][k]);
        end
    end

    always_comb begin
        res = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sh[c] = sum_q[c] >>> SHIFT;
            res[DW-1-c*CH_WIDTH -: CH_WIDTH] = sh[c] < 0 ? '0 : (sh[c] > SW'(MAXV) ? CH_WIDTH'(MAXV) : sh[c][CH_WIDTH-1:0]);
        end
    end

    // row saturates at N-1: deeper rows need no further padding decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_WIDTH'(2 ** SHIFT) : '0;
        end else begin
            if (coef_we && int'(coef_addr) < TAPS) coef[coef_addr] <= coef_data;
            if (accept) begin
                col <= (int'(cur_col) == LINE_WIDTH - 1) ? '0 : cur_col + 1'b1;
                row <= (int'(cur_col) == LINE_WIDTH - 1 && int'(cur_row) < N - 1) ? cur_row + 1'b1 : cur_row;
            end
            if (adv) begin
                v1        <= accept;
                v2        <= v1;
                out_valid <= v2;
                out_data  <= byp2 ? pix2 : res;
                out_sop   <= sop2;
                out_eop   <= eop2;
            end
        end
    end

    // line buffers and window history hold stale data freely; padding masks it on read
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][cur_col] <= in_data;
            for (int i = 1; i < N - 1; i++) lb[i][cur_col] <= lb[i-1][cur_col];
            for (int i = 0; i < N; i++) begin
                hist[i][0] <= colv[i];
                for (int j = 1; j < N - 1; j++) hist[i][j] <= hist[i][j-1];
            end
        end
        if (adv) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            pix1   <= in_data;
            byp1   <= bypass;
            sop1   <= in_sop;
            eop1   <= in_eop;
            pix2   <= pix1;
            byp2   <= byp1;
            sop2   <= sop1;
            eop2   <= eop1;
        end
    end
endmodule

// File: tb/tb_conv_filter_stream.sv
// tb_conv_filter_stream: directed checks of conv_filter_stream against a direct convolution model
module tb_conv_filter_stream;
    localparam int LW = 640;
    localparam int MAXPIX = 4 * LW + 16;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_sop = 0, in_eop = 0, in_ready;
    logic [23:0] in_data = 0;
    logic out_valid, out_sop, out_eop, out_ready = 1;
    logic [23:0] out_data;
    logic coef_we = 0, bypass = 0;
    logic [3:0] coef_addr = 0;
    logic [7:0] coef_data = 0;

    conv_filter_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .bypass(bypass)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] d; logic s; logic e; int t; } cap_t;
    typedef struct { int scen; int row; int col; logic [23:0] exp; } vec_t;

    cap_t q_out[$];
    int q_acc[$];
    vec_t vecs[$];
    int cyc = 0;
    int errors = 0, checks = 0;
    int kern[9];
    int k_id[9]    = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int k_ones[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int k_lap[9]   = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int k_mix[9]   = '{2, -1, 0, -1, 1, 0, 0, 0, 1};
    logic [23:0] img [MAXPIX];
    logic [23:0] out_img [MAXPIX];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst) begin
        if (out_valid && out_ready) q_out.push_back('{out_data, out_sop, out_eop, cyc});
        if (in_valid && in_ready) q_acc.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pixel(input int kind, input int k);
        logic [31:0] x;
        x = k;
        case (kind)
            0: return {x[7:0], x[9:2], ~x[7:0]};
            1: return 24'h0a0a0a;
            2: return 24'hc8c8c8;
            3: return (k == LW + 5) ? 24'hffffff : 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    function automatic logic [23:0] gold(input int k);
        int r, c, s;
        logic [23:0] o;
        r = k / LW;
        c = k % LW;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    if (r >= i && c >= j) s += kern[i*3+j] * int'(img[k - i*LW - j][23-8*ch -: 8]);
            o[23-8*ch -: 8] = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : s[7:0];
        end
        return o;
    endfunction

    task automatic set_kernel(input int kk[9]);
        for (int i = 0; i < 9; i++) begin
            coef_we = 1; coef_addr = 4'(i); coef_data = 8'(kk[i]); kern[i] = kk[i];
            @(posedge clk); #1;
        end
        coef_we = 0;
    endtask

    task automatic stall_seq(input string name);
        logic [23:0] held;
        bit hold_ok, ready_low;
        int t;
        hold_ok = 1; ready_low = 1; held = '0; t = 0;
        while (q_out.size() < 100 && t < 5000) begin @(posedge clk); #1; t++; end
        out_ready = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (s == 0) held = out_data;
            if (!out_valid || out_data !== held) hold_ok = 0;
            if (in_ready) ready_low = 0;
        end
        @(posedge clk); #1;
        out_ready = 1;
        check({name, "_hold_stable"}, 32'(hold_ok), 1);
        check({name, "_in_ready_low"}, 32'(ready_low), 1);
    endtask

    // pre > 0 streams that many 0xffffff pixels (starting with sop) before the frame's own sop
    task automatic run_frame(input string name, input int kind, input int n, input int pre,
                             input bit byp, input bit lat, input bit stall);
        int k, t, bad, lbad, first;
        bit acc;
        logic [23:0] exp, fg, fe;
        for (int i = 0; i < n; i++) img[i] = pixel(kind, i);
        q_out.delete();
        q_acc.delete();
        k = 0; t = 0;
        fork
            begin
                while (k < pre + n && t < 20000) begin
                    in_valid = 1; bypass = byp;
                    in_data = (k < pre) ? 24'hffffff : img[k - pre];
                    in_sop = (k == 0) || (k == pre);
                    in_eop = (k == pre + n - 1);
                    @(negedge clk); acc = in_ready;
                    @(posedge clk); #1;
                    if (acc) k++;
                    t++;
                end
                in_valid = 0; in_sop = 0; in_eop = 0; bypass = 0;
            end
            if (stall) stall_seq(name);
        join
        for (t = 0; t < 2000 && q_out.size() < pre + n; t++) @(negedge clk);
        check({name, "_count"}, q_out.size(), pre + n);
        bad = 0; lbad = 0; first = -1; fg = '0; fe = '0;
        for (int i = 0; i < n && i + pre < q_out.size(); i++) begin
            exp = byp ? img[i] : gold(i);
            out_img[i] = q_out[i+pre].d;
            if (q_out[i+pre].d !== exp || q_out[i+pre].s !== (i == 0) || q_out[i+pre].e !== (i == n - 1)) begin
                bad++;
                if (first < 0) begin first = i; fg = q_out[i+pre].d; fe = exp; end
            end
            if (lat && (i + pre >= q_acc.size() || q_out[i+pre].t - q_acc[i+pre] != 3)) lbad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_data: %0d bad pixels, first at %0d got %h expected %h", name, bad, first, fg, fe);
        end
        if (lat) check({name, "_latency_bad"}, lbad, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_table(input int scen);
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].scen == scen)
                check($sformatf("s%0d_r%0dc%0d", scen, vecs[i].row, vecs[i].col),
                      32'(out_img[vecs[i].row*LW + vecs[i].col]), 32'(vecs[i].exp));
    endtask

    initial begin
        vecs.push_back('{1, 0, 0, 24'h0a0a0a});
        vecs.push_back('{1, 0, 1, 24'h141414});
        vecs.push_back('{1, 0, 2, 24'h1e1e1e});
        vecs.push_back('{1, 0, 639, 24'h1e1e1e});
        vecs.push_back('{1, 1, 0, 24'h141414});
        vecs.push_back('{1, 1, 1, 24'h282828});
        vecs.push_back('{1, 1, 2, 24'h3c3c3c});
        vecs.push_back('{1, 2, 0, 24'h1e1e1e});
        vecs.push_back('{1, 2, 2, 24'h5a5a5a});
        vecs.push_back('{1, 3, 639, 24'h5a5a5a});
        vecs.push_back('{2, 0, 0, 24'h000000});
        vecs.push_back('{2, 1, 1, 24'hffffff});
        vecs.push_back('{2, 2, 1, 24'hffffff});
        vecs.push_back('{2, 2, 0, 24'h000000});
        vecs.push_back('{2, 2, 2, 24'h000000});
        vecs.push_back('{2, 3, 300, 24'h000000});
        vecs.push_back('{3, 2, 6, 24'hffffff});
        vecs.push_back('{3, 1, 5, 24'h000000});
        vecs.push_back('{3, 1, 6, 24'h000000});
        vecs.push_back('{3, 2, 5, 24'h000000});
        vecs.push_back('{3, 2, 7, 24'h000000});
        vecs.push_back('{3, 3, 7, 24'h000000});
        vecs.push_back('{4, 0, 0, 24'h0a0a0a});
        vecs.push_back('{4, 0, 1, 24'h141414});
        vecs.push_back('{4, 0, 2, 24'h1e1e1e});
        vecs.push_back('{4, 1, 1, 24'h282828});

        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_out_sop", 32'(out_sop), 0);
        check("reset_out_eop", 32'(out_eop), 0);
        @(posedge clk); #1;
        kern = k_id;

        run_frame("identity_ramp", 0, 4 * LW, 0, 0, 1, 0);

        set_kernel(k_ones);
        run_frame("ones_const10", 1, 4 * LW, 0, 0, 1, 0);
        check_table(1);

        set_kernel(k_lap);
        run_frame("lap_flat", 2, 4 * LW, 0, 0, 1, 0);
        check_table(2);
        run_frame("lap_dot", 3, 4 * LW, 0, 0, 1, 0);
        check_table(3);

        set_kernel(k_mix);
        run_frame("stall", 4, 2 * LW, 0, 0, 0, 1);
        run_frame("bypass", 4, 2 * LW, 0, 1, 1, 0);

        in_valid = 1;
        for (int i = 0; i < 20; i++) begin
            in_data = 24'($urandom); in_sop = (i == 0);
            @(posedge clk); #1;
        end
        rst = 1; in_valid = 0; in_sop = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        kern = k_id;
        run_frame("after_rst", 4, LW + 40, 0, 0, 1, 0);

        q_out.delete();
        q_acc.delete();
        in_valid = 1; in_sop = 1; in_data = 24'h102030;
        coef_we = 1; coef_addr = 4'd0; coef_data = 8'd2;
        @(posedge clk); #1;
        in_sop = 0; in_data = 24'h010203;
        coef_addr = 4'd9; coef_data = 8'h7f;
        @(posedge clk); #1;
        in_data = 24'h040404;
        coef_we = 0;
        @(posedge clk); #1;
        in_valid = 0;
        for (int t = 0; t < 50 && q_out.size() < 3; t++) @(negedge clk);
        check("coef_count", q_out.size(), 3);
        if (q_out.size() >= 3) begin
            check("coef_same_cycle_old", 32'(q_out[0].d), 32'h102030);
            check("coef_new_applies", 32'(q_out[1].d), 32'h020406);
            check("coef_addr_oob_ignored", 32'(q_out[2].d), 32'h080808);
        end
        @(posedge clk); #1;

        set_kernel(k_ones);
        run_frame("sop_restart", 1, 2 * LW, 12, 0, 1, 0);
        check_table(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
